q2_30_mul: RTL and testbench

Q2_30_MUL -- requirements
Module: q2_30_mul

---
 rtl/q2_30_mul.sv | 146 ++++++++++++++
 tb/tb_q2_30_mul.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_30_mul.sv
// q2_30_mul -- sequential signed multiplier: 32-bit signed integer times a
// signed Q2.30 value, giving a signed Q2.30 result.
// The magnitudes are multiplied by shift-add, one multiplier bit per cycle,
// and the sign is applied at the end. A result is presented 33 cycles after
// the start edge.
// Optional feature: define Q2_30_MUL_SAT_EN to saturate the result on
// overflow. Without it the result wraps. o_overflow behaves the same in both
// builds.
module q2_30_mul (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_multiplicand,
   input  logic [31:0] i_multiplier,
   output logic [31:0] o_product,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_overflow
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      MULTIPLY     = 2'd1,
      SIGN_CORRECT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [31:0] mcand_q, mcand_d;     // |multiplicand|, held for the whole operation
   logic [31:0] mplier_q, mplier_d;   // |multiplier|, shifted right one bit per cycle
   logic [63:0] acc_q, acc_d;         // partial product; holds P when MULTIPLY ends
   logic [5:0]  count_q, count_d;     // multiplier bits still to process
   logic [31:0] product_q, product_d;
   logic        overflow_q, overflow_d;
   logic        done_q, done_d;

   // Helper values for the shift-add step and the final sign correction.
   logic [32:0] sum;
   logic [31:0] mag;
   logic [31:0] wrapped;
   logic        ovf;

   // The upper half of the accumulator adds the multiplicand when the current
   // multiplier bit is set. The accumulator then shifts right so that after
   // 32 steps it holds the full 64-bit product.
   always_comb begin
      sum     = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
      mag     = acc_q[31:0];
      wrapped = sign_q ? (~mag + 32'd1) : mag;
      // A negative result can reach -2^31. A positive result stops at 2^31-1.
      ovf     = sign_q ? (acc_q > 64'h0000_0000_8000_0000)
                       : (acc_q >= 64'h0000_0000_8000_0000);
   end

   // Next-state and datapath control for the three-state sequencer.
   always_comb begin
      // NOTE: every signal gets a default first. Any path through the case
      // that leaves a signal unassigned would otherwise infer a latch.
      state_d    = state_q;
      sign_d     = sign_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      count_d    = count_q;
      product_d  = product_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               sign_d   = i_multiplicand[31] ^ i_multiplier[31];
               // The 32-bit negation of 0x80000000 is 0x80000000. Read as
               // unsigned, that is 2^31, which is the magnitude we need.
               mcand_d  = i_multiplicand[31] ? (~i_multiplicand + 32'd1) : i_multiplicand;
               mplier_d = i_multiplier[31] ? (~i_multiplier + 32'd1) : i_multiplier;
               acc_d    = 64'd0;
               count_d  = 6'd32;
               state_d  = MULTIPLY;
            end
         end

         MULTIPLY: begin
            acc_d    = {sum, acc_q[31:1]};
            mplier_d = {1'b0, mplier_q[31:1]};
            count_d  = count_q - 6'd1;
            if (count_q == 6'd1) begin
               state_d = SIGN_CORRECT;
            end
         end

         SIGN_CORRECT: begin
            overflow_d = ovf;
`ifdef Q2_30_MUL_SAT_EN
            if (ovf) begin
               product_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
               product_d = wrapped;
            end
`else
            product_d = wrapped;
`endif
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only. All flops
      // then sample values from before the edge, whatever order the
      // statements are written in.
      if (i_rst) begin
         state_q    <= IDLE;
         sign_q     <= 1'b0;
         mcand_q    <= 32'd0;
         mplier_q   <= 32'd0;
         acc_q      <= 64'd0;
         count_q    <= 6'd0;
         product_q  <= 32'd0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign o_product  = product_q;
   assign o_overflow = overflow_q;
   assign o_done     = done_q;
   assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_q2_30_mul.sv
// tb_q2_30_mul -- bench for q2_30_mul. It applies a table of fixed vectors,
// several hand-written control sequences, and randomized operands that are
// checked against a signed-arithmetic reference model.
module tb_q2_30_mul;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [31:0] i_multiplicand;
   logic [31:0] i_multiplier;
   logic [31:0] o_product;
   logic        o_done;
   logic        o_busy;
   logic        o_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   q2_30_mul dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_product      (o_product),
      .o_done         (o_done),
      .o_busy         (o_busy),
      .o_overflow     (o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic        o;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model. It forms the exact signed product with 64-bit
   // arithmetic and then applies the Q2.30 range rules to that value.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] p, output logic o);
      longint pr;
      logic [63:0] bits;
      pr   = longint'($signed(a)) * longint'($signed(b));
      bits = pr;
      o    = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
`ifdef Q2_30_MUL_SAT_EN
      if (o) p = (pr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else   p = bits[31:0];
`else
      p = bits[31:0];
`endif
   endtask

   // Starts one operation, scrambles the operands after the start edge, and
   // checks the result value, the overflow flag, the latency and the number
   // of o_done pulses.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input logic exp_o);
      int done_at;
      int n_done;
      done_at = -1;
      n_done  = 0;
      @(negedge i_clk);
      i_multiplicand = a;
      i_multiplier   = b;
      i_start        = 1'b1;
      @(posedge i_clk);
      #1;
      i_start        = 1'b0;
      i_multiplicand = $urandom;
      i_multiplier   = $urandom;
      check({name, " busy"}, 64'(o_busy), 64'd1);
      for (int k = 1; k <= 40; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            n_done++;
            done_at = k;
            check({name, " product"}, 64'(o_product), 64'(exp_p));
            check({name, " overflow"}, 64'(o_overflow), 64'(exp_o));
         end
      end
      check({name, " latency"}, 64'(done_at), 64'd33);
      check({name, " done count"}, 64'(n_done), 64'd1);
      check({name, " product held"}, 64'(o_product), 64'(exp_p));
   endtask

   vec_t vecs[12];

   initial begin
      logic [31:0] ep, ep2;
      logic        eo, eo2;
      logic [31:0] ra, rb;
      int          done_at, n_done, busy_ok, busy_cnt;

      vecs[0]  = '{"unit",        32'd1,          32'h4000_0000, 32'h4000_0000, 1'b0};
      vecs[1]  = '{"neg half",    32'hFFFF_FFFE,  32'h2000_0000, 32'hC000_0000, 1'b0};
      vecs[2]  = '{"edge fn",     32'd48000,      32'h0000_5761, 32'h3FFF_8B80, 1'b0};
`ifdef Q2_30_MUL_SAT_EN
      vecs[3]  = '{"ovf pos",     32'd3,          32'h4000_0000, 32'h7FFF_FFFF, 1'b1};
      vecs[7]  = '{"ovf 2^31",    32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
      vecs[8]  = '{"ovf 2^62",    32'h8000_0000,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
`else
      vecs[3]  = '{"ovf pos",     32'd3,          32'h4000_0000, 32'hC000_0000, 1'b1};
      vecs[7]  = '{"ovf 2^31",    32'hFFFF_FFFF,  32'h8000_0000, 32'h8000_0000, 1'b1};
      vecs[8]  = '{"ovf 2^62",    32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1};
`endif
      vecs[4]  = '{"zero a",      32'd0,          32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[5]  = '{"zero b",      32'hFFFF_FFFB,  32'd0,         32'h0000_0000, 1'b0};
      vecs[6]  = '{"min neg",     32'd1,          32'h8000_0000, 32'h8000_0000, 1'b0};
      vecs[9]  = '{"max pos",     32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0};
      vecs[10] = '{"minus lsb",   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0};
      vecs[11] = '{"neg one x2",  32'd2,          32'hC000_0000, 32'h8000_0000, 1'b0};

      // Reset, with i_start held high to show that it is ignored.
      i_rst = 1'b1;
      i_start = 1'b1;
      i_multiplicand = 32'd7;
      i_multiplier = 32'h4000_0000;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset product", 64'(o_product), 64'd0);
      check("reset done", 64'(o_done), 64'd0);
      check("reset busy", 64'(o_busy), 64'd0);
      check("reset overflow", 64'(o_overflow), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_start = 1'b0;

      // Fixed vectors.
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o);
      end

      // A second start with different operands at cycle 10 is ignored.
      model(32'd5, 32'h1000_0000, ep, eo);
      @(negedge i_clk);
      i_multiplicand = 32'd5;
      i_multiplier   = 32'h1000_0000;
      i_start        = 1'b1;
      @(posedge i_clk);
      #1;
      i_start  = 1'b0;
      done_at  = -1;
      n_done   = 0;
      busy_ok  = 1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin
            @(negedge i_clk);
            i_multiplicand = 32'd9;
            i_multiplier   = 32'h4000_0000;
            i_start        = 1'b1;
         end
         @(posedge i_clk);
         #1;
         i_start = 1'b0;
         if (k <= 32 && !o_busy) busy_ok = 0;
         if (o_done) begin
            n_done++;
            done_at = k;
            check("restart product", 64'(o_product), 64'(ep));
         end
      end
      check("restart latency", 64'(done_at), 64'd33);
      check("restart done count", 64'(n_done), 64'd1);
      check("restart busy held", 64'(busy_ok), 64'd1);

      // i_start held high: back-to-back operations, one per 34 cycles.
      model(32'hFFFF_FFFD, 32'h0C00_0000, ep, eo);
      @(negedge i_clk);
      i_multiplicand = 32'hFFFF_FFFD;
      i_multiplier   = 32'h0C00_0000;
      i_start        = 1'b1;
      @(posedge i_clk);
      #1;
      n_done   = 0;
      done_at  = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 70; k++) begin
         @(posedge i_clk);
         #1;
         if (o_busy) busy_cnt++;
         if (o_done) begin
            n_done++;
            if (n_done == 1) check("held start first at", 64'(k), 64'd33);
            if (n_done == 2) done_at = k;
            check("held start product", 64'(o_product), 64'(ep));
         end
      end
      check("held start second at", 64'(done_at), 64'd67);
      check("held start done count", 64'(n_done), 64'd2);
      @(negedge i_clk);
      i_start = 1'b0;
      // Let any operation the held start may have begun run to completion.
      repeat (40) @(posedge i_clk);

      // Reset in the middle of MULTIPLY after an overflowing result, so the
      // outputs are non-zero before the reset.
      run_op("pre-reset", 32'd3, 32'h4000_0000, vecs[3].p, 1'b1);
      @(negedge i_clk);
      i_multiplicand = 32'd11;
      i_multiplier   = 32'h4000_0000;
      i_start        = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (20) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("abort product", 64'(o_product), 64'd0);
      check("abort overflow", 64'(o_overflow), 64'd0);
      check("abort busy", 64'(o_busy), 64'd0);
      check("abort done", 64'(o_done), 64'd0);
      @(negedge i_clk);
      i_rst  = 1'b0;
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) n_done++;
      end
      check("abort no done", 64'(n_done), 64'd0);
      run_op("post-reset", 32'd1, 32'h4000_0000, 32'h4000_0000, 1'b0);

      // Randomized operands. Some draws are forced to zero or to extreme
      // values so that the boundary cases come up often.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'd0;
            1: rb = 32'h8000_0000;
            2: ra = $urandom_range(0, 8) - 4;
            3: rb = rb >> $urandom_range(1, 31);
            4: ra = ra >>> $urandom_range(8, 31);
            default: ;
         endcase
         model(ra, rb, ep2, eo2);
         run_op("random", ra, rb, ep2, eo2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
